quantser_array: RTL and testbench

Multi-lane quantizer/serializer with rounding, saturation and valid/ready flow control. Accepts a vector of N wide words, reduces each to a runtime-selected precision at a runtime-selected MSB position, and emits them MSB-first, one bit per lane per beat. Sits between the accumulator/activation path and the bit-serial operand bus of the next MVU stage. A one-word holding register allows gap-free back-to-back words.

---
 rtl/quantser_pkg.sv | 21 ++
 rtl/quantser_lane.sv | 64 ++++++
 rtl/quantser_array.sv | 151 +++++++++++++++
 tb/tb_quantser_array.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quantser_pkg.sv
// Shared definitions for the multi-lane quantizer/serializer: FSM encoding,
// precision-config width derivation and the precision clamp.
package quantser_pkg;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  function automatic int unsigned prec_width(input int unsigned bwin);
    return $clog2(bwin) + 1;
  endfunction

  // A precision of 0 behaves as 1; anything wider than the input word is capped.
  function automatic int unsigned clamp_prec(input int unsigned prec, input int unsigned bwin);
    if (prec == 0) return 1;
    if (prec > bwin) return bwin;
    return prec;
  endfunction

endpackage

// File: rtl/quantser_lane.sv
// One lane's quantizer: field extract, round half-up, overflow detect and
// saturate/wrap. Result is returned left-aligned so the serializer shifts MSB-first.
module quantser_lane
  import quantser_pkg::*;
#(
  parameter int BWIN     = 32,
  parameter int BWMSBIDX = $clog2(BWIN),
  parameter int BWPREC   = prec_width(BWIN)
) (
  input  logic [BWIN-1:0]     word_i,
  input  logic [BWMSBIDX-1:0] msbidx_i,
  input  logic [BWPREC-1:0]   prec_i,
  input  logic                signed_i,
  input  logic                round_i,
  input  logic                sat_i,
  output logic [BWIN-1:0]     q_o,
  output logic                sat_o
);

  localparam int W = BWIN + 2;

  int unsigned       m, p, sa;
  logic [2*BWIN-1:0] wide;
  logic              rb;
  logic [W-1:0]      mask, field_u, rbit, sum_u, maxpos, minneg, res, lsh;
  logic signed [W-1:0] field_s, sum_s;
  logic [BWIN-1:0]   hi_u, hi_s;
  logic              above_u, above_s, ovf;

  always_comb begin
    m = 32'(msbidx_i);
    p = 32'(prec_i);
    // Zero padding below bit 0 makes fields that dip under the LSB read as 0.
    wide = {word_i, {BWIN{1'b0}}};
    sa   = BWIN + m + 1 - p;
    mask    = (W'(1) << p) - W'(1);
    field_u = W'(wide >> sa) & mask;
    rb      = 1'(wide >> (sa - 1));
    rbit    = round_i ? W'(rb) : '0;
    sum_u   = field_u + rbit;

    lsh     = field_u << (W - p);
    field_s = $signed(lsh) >>> (W - p);
    sum_s   = field_s + $signed(rbit);
    maxpos  = (W'(1) << (p - 1)) - W'(1);
    minneg  = ~maxpos;

    hi_u    = word_i >> m;
    hi_s    = $signed(word_i) >>> m;
    above_u = (hi_u >> 1) != '0;
    above_s = (hi_s != '0) && (hi_s != '1);

    if (signed_i) ovf = above_s || (sum_s > $signed(maxpos));
    else          ovf = above_u || ((sum_u & ~mask) != '0);

    if (sat_i && ovf) res = signed_i ? (word_i[BWIN-1] ? minneg : maxpos) : mask;
    else              res = signed_i ? unsigned'(sum_s) : sum_u;
    res = res & mask;

    q_o   = BWIN'(res) << (BWIN - p);
    sat_o = sat_i && ovf;
  end

endmodule

// File: rtl/quantser_array.sv
// N-lane quantizer/serializer: quantizes a word vector on acceptance and shifts
// it out MSB-first, one bit per lane per beat, with a one-word holding register.
module quantser_array
  import quantser_pkg::*;
#(
  parameter int N        = 8,
  parameter int BWIN     = 32,
  parameter int BWMSBIDX = $clog2(BWIN),
  parameter int BWPREC   = prec_width(BWIN)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [BWMSBIDX-1:0] cfg_msbidx,
  input  logic [BWPREC-1:0]   cfg_prec,
  input  logic                cfg_signed,
  input  logic                cfg_round,
  input  logic                cfg_sat,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*BWIN-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_data,
  output logic                out_first,
  output logic                out_last,
  output logic [N-1:0]        out_sat
);

  state_e                 state_q, state_d;
  logic [N-1:0][BWIN-1:0] sr_q, sr_d, hold_q, hold_d, q_w;
  logic [N-1:0]           sat_q, sat_d, hsat_q, hsat_d, s_w;
  logic [BWPREC-1:0]      cnt_q, cnt_d, prec_q, prec_d, hprec_q, hprec_d, prec_c;
  logic                   hvalid_q, hvalid_d;
  logic                   accept, beat, last_beat;

  assign prec_c    = BWPREC'(clamp_prec(32'(cfg_prec), BWIN));
  assign accept    = in_valid & in_ready;
  assign beat      = out_valid & out_ready;
  assign last_beat = beat & out_last;

  for (genvar k = 0; k < N; k++) begin : g_lane
    quantser_lane #(
      .BWIN    (BWIN),
      .BWMSBIDX(BWMSBIDX),
      .BWPREC  (BWPREC)
    ) u_lane (
      .word_i  (in_data[k*BWIN +: BWIN]),
      .msbidx_i(cfg_msbidx),
      .prec_i  (prec_c),
      .signed_i(cfg_signed),
      .round_i (cfg_round),
      .sat_i   (cfg_sat),
      .q_o     (q_w[k]),
      .sat_o   (s_w[k])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      prec_q   <= '0;
      sat_q    <= '0;
      hold_q   <= '0;
      hprec_q  <= '0;
      hsat_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      prec_q   <= prec_d;
      sat_q    <= sat_d;
      hold_q   <= hold_d;
      hprec_q  <= hprec_d;
      hsat_q   <= hsat_d;
      hvalid_q <= hvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    prec_d   = prec_q;
    sat_d    = sat_q;
    hold_d   = hold_q;
    hprec_d  = hprec_q;
    hsat_d   = hsat_q;
    hvalid_d = hvalid_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d    = q_w;
          cnt_d   = prec_c - 1'b1;
          prec_d  = prec_c;
          sat_d   = s_w;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // On the final beat the next word (held first, else incoming) loads without a bubble.
        if (last_beat) begin
          if (hvalid_q) begin
            sr_d     = hold_q;
            cnt_d    = hprec_q - 1'b1;
            prec_d   = hprec_q;
            sat_d    = hsat_q;
            hvalid_d = 1'b0;
          end else if (accept) begin
            sr_d   = q_w;
            cnt_d  = prec_c - 1'b1;
            prec_d = prec_c;
            sat_d  = s_w;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (beat) begin
            for (int unsigned k = 0; k < N; k++) sr_d[k] = {sr_q[k][BWIN-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
          end
          if (accept) begin
            hold_d   = q_w;
            hprec_d  = prec_c;
            hsat_d   = s_w;
            hvalid_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = ~clr & ~hvalid_q;
    out_valid = (state_q == S_SHIFT);
    out_data  = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_sat   = '0;
    if (out_valid) begin
      for (int unsigned k = 0; k < N; k++) out_data[k] = sr_q[k][BWIN-1];
      out_first = (cnt_q == prec_q - 1'b1);
      out_last  = (cnt_q == '0);
      out_sat   = sat_q;
    end
  end

endmodule

// File: tb/tb_quantser_array.sv
// Directed bench for quantser_array: table of quantization vectors plus
// hand-written backpressure, back-to-back and mid-word clear sequences.
module tb_quantser_array;

  localparam int N        = 8;
  localparam int BWIN     = 32;
  localparam int BWMSBIDX = 5;
  localparam int BWPREC   = 6;

  logic                clk = 1'b0;
  logic                clr;
  logic [BWMSBIDX-1:0] cfg_msbidx;
  logic [BWPREC-1:0]   cfg_prec;
  logic                cfg_signed, cfg_round, cfg_sat;
  logic                in_valid, in_ready;
  logic [N*BWIN-1:0]   in_data;
  logic                out_valid, out_ready;
  logic [N-1:0]        out_data, out_sat;
  logic                out_first, out_last;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  quantser_array #(
    .N       (N),
    .BWIN    (BWIN),
    .BWMSBIDX(BWMSBIDX),
    .BWPREC  (BWPREC)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .cfg_msbidx(cfg_msbidx),
    .cfg_prec  (cfg_prec),
    .cfg_signed(cfg_signed),
    .cfg_round (cfg_round),
    .cfg_sat   (cfg_sat),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  // Even lanes carry d0, odd lanes d1; e*/s* are the hand-computed results.
  typedef struct {
    logic [31:0] d0, d1;
    logic [4:0]  m;
    logic [5:0]  p;
    logic        sg, rn, st;
    int          pc;
    logic [31:0] e0, e1;
    logic        s0, s1;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < N; k++) in_data[k*BWIN +: BWIN] = (k % 2 == 0) ? a : b;
  endtask

  task automatic set_cfg(input logic [4:0] m, input logic [5:0] p, input logic sg,
                         input logic rn, input logic st);
    cfg_msbidx = m;
    cfg_prec   = p;
    cfg_signed = sg;
    cfg_round  = rn;
    cfg_sat    = st;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] gw [N];
    logic        proto_ok;
    @(negedge clk);
    set_cfg(v.m, v.p, v.sg, v.rn, v.st);
    drive(v.d0, v.d1);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    for (int k = 0; k < N; k++) gw[k] = '0;
    proto_ok = 1'b1;
    for (int b = 0; b < v.pc; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (b == 0) check({tag, " out_sat"}, 64'(out_sat), 64'({4{v.s1, v.s0}}));
      proto_ok = proto_ok & out_valid & (out_first == (b == 0)) & (out_last == (b == v.pc - 1));
      for (int k = 0; k < N; k++) gw[k] = {gw[k][30:0], out_data[k]};
    end
    check({tag, " valid/first/last"}, 64'(proto_ok), 64'd1);
    for (int k = 0; k < N; k++)
      check($sformatf("%s lane%0d", tag, k), 64'(gw[k]), 64'((k % 2 == 0) ? v.e0 : v.e1));
  endtask

  task automatic b2b(input int p, input logic [4:0] m, input logic [2:0][31:0] w,
                     input int nexp, input logic [11:0] ebits, input logic exp_stall,
                     input string tag);
    int          idx, nb;
    logic        pend, started, gap, sawstall, first_ok, last_ok;
    logic [11:0] bits;
    idx = 0; nb = 0; started = 1'b0; gap = 1'b0; sawstall = 1'b0;
    first_ok = 1'b1; last_ok = 1'b1; bits = '0;
    @(negedge clk);
    set_cfg(m, 6'(p), 1'b0, 1'b0, 1'b0);
    drive(w[0], w[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    pend = in_ready;
    for (int c = 0; c < 40 && nb < nexp; c++) begin
      @(negedge clk);
      if (out_valid) begin
        started  = 1'b1;
        bits     = {bits[10:0], out_data[0]};
        first_ok = first_ok & (out_first == (nb % p == 0));
        last_ok  = last_ok & (out_last == (nb % p == p - 1));
        nb++;
      end else if (started) begin
        gap = 1'b1;
      end
      if (pend) idx++;
      if (idx < 3) begin
        drive(w[idx], w[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (!in_ready) sawstall = 1'b1;
      pend = in_valid && in_ready;
    end
    in_valid = 1'b0;
    check({tag, " beats"}, 64'(nb), 64'(nexp));
    check({tag, " no bubble"}, 64'(gap), 64'd0);
    check({tag, " bits"}, 64'(bits), 64'(ebits));
    check({tag, " first flags"}, 64'(first_ok), 64'd1);
    check({tag, " last flags"}, 64'(last_ok), 64'd1);
    check({tag, " in_ready stall"}, 64'(sawstall), 64'(exp_stall));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] got;
    int         nb, last_c;
    logic       held_ok;

    vecs[0]  = '{32'hA5, 32'h3C, 5'd7, 6'd8, 1'b0, 1'b0, 1'b0, 8, 32'hA5, 32'h3C, 1'b0, 1'b0};
    vecs[1]  = '{32'h58, 32'h57, 5'd7, 6'd4, 1'b0, 1'b1, 1'b0, 4, 32'h6, 32'h5, 1'b0, 1'b0};
    vecs[2]  = '{32'h58, 32'h4F, 5'd7, 6'd4, 1'b0, 1'b0, 1'b0, 4, 32'h5, 32'h4, 1'b0, 1'b0};
    vecs[3]  = '{32'h7F, 32'hFFFFFF80, 5'd7, 6'd4, 1'b1, 1'b1, 1'b1, 4, 32'h7, 32'h8, 1'b1, 1'b0};
    vecs[4]  = '{32'h7F, 32'hFFFFFF88, 5'd7, 6'd4, 1'b1, 1'b1, 1'b0, 4, 32'h8, 32'h9, 1'b0, 1'b0};
    vecs[5]  = '{32'h1F0, 32'hF8, 5'd7, 6'd4, 1'b0, 1'b1, 1'b1, 4, 32'hF, 32'hF, 1'b1, 1'b1};
    vecs[6]  = '{32'h1A0, 32'hF8, 5'd7, 6'd4, 1'b0, 1'b1, 1'b0, 4, 32'hA, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h7FFFFFFF, 5'd31, 6'd1, 1'b0, 1'b0, 1'b0, 1, 32'h1, 32'h0, 1'b0, 1'b0};
    vecs[8]  = '{32'h1, 32'h2, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1, 32'h1, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{32'hDEADBEEF, 32'h12345678, 5'd31, 6'd40, 1'b0, 1'b1, 1'b1, 32, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0};
    vecs[10] = '{32'hFFFFFF00, 32'h5, 5'd3, 6'd4, 1'b1, 1'b1, 1'b1, 4, 32'h8, 32'h5, 1'b1, 1'b0};
    vecs[11] = '{32'h3, 32'h6, 5'd1, 6'd4, 1'b0, 1'b1, 1'b1, 4, 32'hC, 32'hF, 1'b0, 1'b1};
    vecs[12] = '{32'h7FFFFFFF, 32'h80000000, 5'd31, 6'd8, 1'b1, 1'b1, 1'b1, 8, 32'h7F, 32'h80, 1'b1, 1'b0};

    clr       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    set_cfg(5'd7, 6'd8, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_first/last", 64'({out_first, out_last}), 64'd0);
    check("reset out_sat", 64'(out_sat), 64'd0);
    clr = 1'b0;
    #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: stall three cycles after the second beat.
    @(negedge clk);
    set_cfg(5'd7, 6'd8, 1'b0, 1'b0, 1'b0);
    drive(32'hA5, 32'h5A);
    in_valid = 1'b1;
    got = '0; nb = 0; last_c = 0; held_ok = 1'b1;
    for (int c = 1; c <= 20 && last_c == 0; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = !(c >= 3 && c <= 5);
      if (out_valid) begin
        if (out_ready) begin
          got = {got[6:0], out_data[0]};
          nb++;
          if (out_last) last_c = c;
        end else begin
          held_ok = held_ok & (out_data[0] == 1'b1) & !out_first & !out_last;
        end
      end
    end
    out_ready = 1'b1;
    check("bp word", 64'(got), 64'hA5);
    check("bp beats", 64'(nb), 64'd8);
    check("bp last cycle", 64'(last_c), 64'd11);
    check("bp held bit", 64'(held_ok), 64'd1);

    b2b(4, 5'd3, {32'hC, 32'h6, 32'h9}, 12, 12'h96C, 1'b1, "b2b prec4");
    b2b(1, 5'd0, {32'h7, 32'hE, 32'h1}, 3, 12'h005, 1'b0, "b2b prec1");

    // Clear mid-word with the holding register full.
    @(negedge clk);
    set_cfg(5'd7, 6'd8, 1'b0, 1'b0, 1'b0);
    drive(32'hA5, 32'hA5);
    in_valid = 1'b1;
    @(negedge clk);
    drive(32'hFF, 32'hFF);
    @(negedge clk);
    in_valid = 1'b0;
    check("clr hold full", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("clr 3rd beat", 64'({out_valid, out_data[0]}), 64'b11);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("clr out_valid", 64'(out_valid), 64'd0);
    check("clr in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("clr hold discarded", 64'(out_valid), 64'd0);
    run_vec(vecs[0], "after clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
